// File: rtl/sub_serial_4_if.sv
// Operand/result handshake bundle for the
// bit-serial 4-bit subtractor.
interface sub_serial_4_if;
  logic       valid_in;
  logic       ready_in;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic       B_1;
  logic       valid_out;
  logic       ready_out;
  logic [3:0] D;
  logic       BO;

  modport master (
    output valid_in,
    input  ready_in,
    output A_in,
    output B_in,
    output B_1,
    input  valid_out,
    output ready_out,
    input  D,
    input  BO
  );

  modport slave (
    input  valid_in,
    output ready_in,
    input  A_in,
    input  B_in,
    input  B_1,
    output valid_out,
    input  ready_out,
    output D,
    output BO
  );
endinterface

// File: rtl/sub_serial_4.sv
// Bit-serial 4-bit subtractor, LSB first,
// one bit per cycle, valid/ready on both sides.
module sub_serial_4 (
  input  logic          clk,
  input  logic          rst_n,
  sub_serial_4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       br;
  logic [3:0] res;
  logic [3:0] d_q;
  logic       bo_q;
  logic       rdy_q;
  logic       vld_q;

  logic a_i;
  logic b_i;
  logic d_i;
  logic br_nx;

  always_comb begin
    a_i   = a_q[cnt];
    b_i   = b_q[cnt];
    d_i   = a_i ^ b_i ^ br;
    br_nx = (~a_i & b_i)
          | (~(a_i ^ b_i) & br);
  end

  // D/BO are only updated at completion so
  // partial bits never leak to the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      a_q   <= 4'd0;
      b_q   <= 4'd0;
      br    <= 1'b0;
      res   <= 4'd0;
      d_q   <= 4'd0;
      bo_q  <= 1'b0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.valid_in && rdy_q) begin
            a_q   <= bus.A_in;
            b_q   <= bus.B_in;
            br    <= bus.B_1;
            cnt   <= 2'd0;
            state <= CALC;
            rdy_q <= 1'b0;
          end
        end
        CALC: begin
          res[cnt] <= d_i;
          br       <= br_nx;
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            d_q   <= {d_i, res[2:0]};
            bo_q  <= br_nx;
            state <= DONE;
            vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_out) begin
            state <= IDLE;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_in  = rdy_q;
  assign bus.valid_out = vld_q;
  assign bus.D         = d_q;
  assign bus.BO        = bo_q;

endmodule

// File: tb/tb_sub_serial_4.sv
// Directed + random bench for sub_serial_4
// against an arithmetic reference model.
module tb_sub_serial_4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sub_serial_4_if bus ();

  sub_serial_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string    tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_d(
    input int a, input int b, input int c
  );
    int r;
    r = (a - b - c) & 15;
    return r[3:0];
  endfunction

  function automatic logic ref_bo(
    input int a, input int b, input int c
  );
    return a < (b + c);
  endfunction

  logic [3:0] last_d;
  logic       last_bo;

  task automatic run_op(
    input int a,
    input int b,
    input int c,
    input int hold,
    input bit tgl
  );
    logic [3:0] ed;
    logic       eb;
    ed = ref_d(a, b, c);
    eb = ref_bo(a, b, c);
    @(negedge clk);
    chk("ready_idle", {7'd0, bus.ready_in}, 8'd1);
    bus.valid_in  = 1'b1;
    bus.A_in      = a[3:0];
    bus.B_in      = b[3:0];
    bus.B_1       = c[0];
    bus.ready_out = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("calc_valid",
          {7'd0, bus.valid_out}, 8'd0);
      chk("calc_ready",
          {7'd0, bus.ready_in}, 8'd0);
      chk("calc_d_hold", {4'd0, bus.D},
          {4'd0, last_d});
      bus.valid_in  = 1'($urandom);
      bus.ready_out = 1'($urandom);
      if (tgl) begin
        bus.A_in = 4'($urandom);
        bus.B_in = 4'($urandom);
        bus.B_1  = 1'($urandom);
      end
    end
    @(negedge clk);
    chk("done_valid", {7'd0, bus.valid_out}, 8'd1);
    chk("done_d", {4'd0, bus.D}, {4'd0, ed});
    chk("done_bo", {7'd0, bus.BO}, {7'd0, eb});
    chk("done_ready", {7'd0, bus.ready_in}, 8'd0);
    bus.ready_out = 1'b0;
    for (int k = 0; k < hold; k++) begin
      bus.valid_in = 1'($urandom);
      bus.A_in     = 4'($urandom);
      @(negedge clk);
      chk("bp_valid",
          {7'd0, bus.valid_out}, 8'd1);
      chk("bp_d", {4'd0, bus.D}, {4'd0, ed});
      chk("bp_bo", {7'd0, bus.BO}, {7'd0, eb});
      chk("bp_ready",
          {7'd0, bus.ready_in}, 8'd0);
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    @(negedge clk);
    chk("hand_valid", {7'd0, bus.valid_out}, 8'd0);
    chk("hand_ready", {7'd0, bus.ready_in}, 8'd1);
    chk("keep_d", {4'd0, bus.D}, {4'd0, ed});
    chk("keep_bo", {7'd0, bus.BO}, {7'd0, eb});
    bus.ready_out = 1'b0;
    last_d  = ed;
    last_bo = eb;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    last_d        = 4'd0;
    last_bo       = 1'b0;
    rst_n         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    bus.A_in      = 4'd0;
    bus.B_in      = 4'd0;
    bus.B_1       = 1'b0;
    #12;
    chk("rst_ready", {7'd0, bus.ready_in}, 8'd1);
    chk("rst_valid", {7'd0, bus.valid_out}, 8'd0);
    chk("rst_d", {4'd0, bus.D}, 8'd0);
    chk("rst_bo", {7'd0, bus.BO}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1, 3, 0, 0, 0);
    run_op(11, 3, 1, 0, 0);
    run_op(11, 4, 1, 0, 0);
    run_op(8, 5, 0, 0, 0);
    run_op(0, 15, 1, 0, 0);
    run_op(15, 0, 0, 0, 0);
    run_op(15, 15, 1, 1, 1);
    run_op(6, 9, 0, 3, 0);
    run_op(13, 2, 1, 2, 1);

    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.A_in     = 4'd11;
    bus.B_in     = 4'd4;
    bus.B_1      = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_d", {4'd0, bus.D}, 8'd0);
    chk("abort_bo", {7'd0, bus.BO}, 8'd0);
    chk("abort_valid",
        {7'd0, bus.valid_out}, 8'd0);
    chk("abort_ready",
        {7'd0, bus.ready_in}, 8'd1);
    last_d  = 4'd0;
    last_bo = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_nopulse",
          {7'd0, bus.valid_out}, 8'd0);
    end
    bus.ready_out = 1'b0;

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(15)),
             int'($urandom_range(15)),
             int'($urandom_range(1)),
             int'($urandom_range(3)),
             1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_serial_4.md
SUB_SERIAL_4 -- requirements
Module: sub_serial_4

Interface
REQ-001 SHALL use one clock and one reset; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: valid_in  input  1  operands A_in/B_in/B_1 are valid this cycle.
REQ-005 SHALL have port: ready_in  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: A_in  input  4  minuend, unsigned.
REQ-007 SHALL have port: B_in  input  4  subtrahend, unsigned.
REQ-008 SHALL have port: B_1  input  1  borrow-in.
REQ-009 SHALL have port: valid_out  output  1  D/BO hold a completed result.
REQ-010 SHALL have port: ready_out  input  1  downstream consumes result this cycle.
REQ-011 SHALL have port: D  output  4  difference, low 4 bits of A_in - B_in - B_1.
REQ-012 SHALL have port: BO  output  1  borrow-out; 1 iff A_in < B_in + B_1.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, CALC, DONE; all state, counter, operand, borrow and result registers clocked on rising clk.
REQ-014 SHALL drive ready_in = 1 only in IDLE (registered-state decode); valid_out = 1 only in DONE.
REQ-015 SHALL, in IDLE on valid_in && ready_in at edge T0, latch A_in, B_in, B_1 into internal registers, clear the 2-bit bit counter, and enter CALC.
REQ-016 SHALL ignore valid_in and operand changes whenever ready_in = 0; latched operands alone determine the result.
REQ-017 SHALL, in CALC, resolve exactly one bit per cycle, LSB first: d_i = a_i XOR b_i XOR br; br_next = (~a_i & b_i) | (~(a_i XOR b_i) & br); br initialised to latched B_1.
REQ-018 SHALL process bit i at edge T0+1+i (i = 0..3), write d_i into result bit i, and increment the counter modulo 4.
REQ-019 SHALL, at edge T0+4 (counter wrap 3->0), load BO with the final borrow, enter DONE; valid_out first high in the cycle after T0+4 (latency 4 cycles from accept edge to valid_out).
REQ-020 SHALL NOT change D or BO while valid_out = 1; partial results SHALL NOT be visible as valid.
REQ-021 SHALL, in DONE, remain in DONE holding outputs while ready_out = 0; on ready_out = 1 at an edge, return to IDLE.
REQ-022 SHALL NOT accept new operands in the same cycle as result handoff (ready_in = 0 in DONE); minimum accept-to-accept spacing is 6 cycles.
REQ-023 SHALL retain D and BO after returning to IDLE until next completion overwrites them.
REQ-024 SHALL ignore ready_out outside DONE.
REQ-025 SHALL handle full-range wrap-around: result modulo 16 with BO flagging underflow, including B_in = 15 with B_1 = 1.

Reset
REQ-026 SHALL, on rst_n = 0 asynchronously, force state IDLE, counter 0, internal borrow 0, latched operands 0, D = 4'd0, BO = 0, valid_out = 0, ready_in = 1 (from IDLE decode).
REQ-027 SHALL, on reset asserted during CALC or DONE, abandon the operation with no result ever presented; after rst_n deasserts, first accept occurs on first edge with valid_in = 1.

Verification
REQ-028 SHALL cover: A_in=1, B_in=3, B_1=0 accepted -> 4 cycles later valid_out=1, D=4'd14, BO=1.
REQ-029 SHALL cover: sequence (11,3,1), (11,4,1), (8,5,0) each with ready_out=1 -> D=7/BO=0, D=6/BO=0, D=3/BO=0 in order, each after 4-cycle latency.
REQ-030 SHALL cover boundary: A_in=0, B_in=15, B_1=1 -> D=4'd0, BO=1; and A_in=15, B_in=0, B_1=0 -> D=4'd15, BO=0.
REQ-031 SHALL cover backpressure: ready_out held 0 for 3 cycles in DONE -> valid_out, D, BO stable, ready_in=0, valid_in pulses ignored; ready_out=1 -> IDLE next cycle.
REQ-032 SHALL cover operand change: A_in/B_in toggled every cycle during CALC -> result equals latched operands only.
REQ-033 SHALL cover reset mid-CALC at bit 2 -> immediately D=0, BO=0, valid_out=0, ready_in=1; no valid_out pulse for aborted operation.
